// File: rtl/network_sequencer_if.sv
// Sample and result valid/ready streams of the network sequencer.
interface network_sequencer_if #(
    parameter int W = 16,
    parameter int C = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   inp;
    logic [C*W-1:0] out;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output in_valid, inp, out_ready,
        input  in_ready, out, out_valid
    );

    modport slave (
        input  in_valid, inp, out_ready,
        output in_ready, out, out_valid
    );
endinterface

// File: rtl/network_sequencer.sv
// Control sequencer for the cached dilated causal conv stack:
// shift, run each layer, advance caches, capture the final output.
module network_sequencer #(
    parameter int W          = 16,
    parameter int C          = 4,
    parameter int NUM_LAYERS = 3,
    parameter int TIMEOUT    = 255,
    localparam int CW        = (NUM_LAYERS > 1) ? NUM_LAYERS - 1 : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    network_sequencer_if.slave    io,
    output logic [W-1:0]          lsb_data,
    output logic                  lsb_shift_en,
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [CW-1:0]         cache_shift_en,
    input  logic [C*W-1:0]        layer_out,
    output logic                  busy,
    output logic                  err,
    output logic [15:0]           sample_cnt
);
    localparam int IW  = $clog2(NUM_LAYERS + 1);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]         LAST = IW'(NUM_LAYERS - 1);
    localparam logic [WDW-1:0]        WMAX = WDW'(TIMEOUT - 1);
    localparam logic [NUM_LAYERS-1:0] ONE  = 1;
    localparam logic [CW-1:0]         CONE = 1;

    typedef enum logic [2:0] {
        IDLE, SHIFT, START, WAIT, CACHE, CAPTURE
    } state_t;

    state_t         state;
    logic [IW-1:0]  idx;
    logic [WDW-1:0] wdog;
    logic [CW-1:0]  cache_q;
    logic           done_sel;

    assign done_sel = |(layer_done & (ONE << idx));
    assign cache_shift_en = (NUM_LAYERS > 1) ? cache_q : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            idx          <= '0;
            wdog         <= '0;
            cache_q      <= '0;
            lsb_data     <= '0;
            lsb_shift_en <= 1'b0;
            layer_start  <= '0;
            io.in_ready  <= 1'b1;
            io.out       <= '0;
            io.out_valid <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            sample_cnt   <= '0;
        end else begin
            lsb_shift_en <= 1'b0;
            layer_start  <= '0;
            cache_q      <= '0;
            // a capture later in this block overrides the consume
            if (io.out_valid && io.out_ready)
                io.out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        lsb_data     <= io.inp;
                        idx          <= '0;
                        lsb_shift_en <= 1'b1;
                        io.in_ready  <= 1'b0;
                        busy         <= 1'b1;
                        state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    layer_start <= ONE;
                    state       <= START;
                end
                START: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (done_sel) begin
                        if (idx == LAST) begin
                            state <= CAPTURE;
                        end else begin
                            cache_q <= CONE << idx;
                            state   <= CACHE;
                        end
                    end else if (wdog == WMAX) begin
                        err         <= 1'b1;
                        io.in_ready <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                CACHE: begin
                    idx         <= idx + 1'b1;
                    layer_start <= ONE << (idx + 1'b1);
                    state       <= START;
                end
                CAPTURE: begin
                    if (!io.out_valid || io.out_ready) begin
                        io.out       <= layer_out;
                        io.out_valid <= 1'b1;
                        sample_cnt   <= sample_cnt + 1'b1;
                        io.in_ready  <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/network_sequencer.md
# network_sequencer

Parametrised, single-clock control sequencer for the cached dilated causal convolution stack. It accepts one input sample through a valid/ready handshake and steps the left shift buffer. It then runs each of NUM_LAYERS conv1d blocks in order, advancing each inter-layer activation cache after its layer completes, and presents the final layer's C-channel result through a valid/ready output register. All downstream blocks are advanced with single-cycle enables, not derived clocks. A per-layer watchdog aborts a hung layer.

## Interface

Parameters:
- W, 16: element width, signed two's complement.
- C, 4: channels per layer output.
- NUM_LAYERS, 3: conv layers sequenced; legal range 1..15.
- TIMEOUT, 255: maximum WAIT cycles per layer before abort; legal range ≥1.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  input sample offered.
- in_ready  out  1  sequencer accepts a sample this cycle.
- inp  in  W  input sample, captured on in_valid & in_ready.
- lsb_data  out  W  registered accepted sample, driven to the left shift buffer.
- lsb_shift_en  out  1  one-cycle shift strobe to the left shift buffer.
- layer_start  out  NUM_LAYERS  one-hot, one-cycle start/reset pulse to conv layer l.
- layer_done  in  NUM_LAYERS  out_v from each conv layer.
- cache_shift_en  out  max(NUM_LAYERS-1,1)  one-cycle capture strobe to activation cache l (after layer l).
- layer_out  in  C*W  last layer outputs; channel k at bits [k*W +: W].
- out  out  C*W  registered network output.
- out_valid  out  1  out holds an unconsumed result.
- out_ready  in  1  consumer takes out when out_valid is high.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky watchdog flag.
- sample_cnt  out  16  count of results captured, wraps modulo 2^16.

## Operation

- States: IDLE, SHIFT, START, WAIT, CACHE, CAPTURE. Layer index idx has width clog2(NUM_LAYERS+1).
- IDLE: in_ready=1. On in_valid, lsb_data<=inp, idx<=0, go to SHIFT.
- SHIFT: lsb_shift_en=1. Go to START.
- START: layer_start[idx]=1, wdog<=0. Go to WAIT.
- WAIT: sample layer_done[idx] each cycle.
  - If done and idx<NUM_LAYERS-1, go to CACHE.
  - If done and idx==NUM_LAYERS-1, go to CAPTURE.
  - Else, if wdog==TIMEOUT-1: err<=1, go to IDLE (sample dropped, no capture, sample_cnt unchanged).
  - Otherwise wdog++.
- CACHE: cache_shift_en[idx]=1, idx++. Go to START.
- CAPTURE: if !out_valid or out_ready: out<=layer_out, out_valid<=1, sample_cnt++, go to IDLE. Otherwise stall in CAPTURE; layer_out must stay stable while layer_done is held.
- Output register, in any state: out_valid & out_ready with no simultaneous capture clears out_valid. A capture in the same cycle keeps out_valid=1 and loads the new data.
- layer_done bits other than layer_done[idx], and all layer_done bits outside WAIT, are ignored.
- in_valid is ignored outside IDLE.
- Strobes are Moore-decoded from state and idx and are glitch-free registered-state decodes. At most one strobe is high in any cycle.
- NUM_LAYERS=1: CACHE is never entered and cache_shift_en is tied to 0.

## Timing

- Reset values: in_ready=1 (state IDLE), lsb_data=0, out=0, out_valid=0, busy=0, err=0, sample_cnt=0, all strobes 0.
- Reset mid-operation returns to IDLE immediately. Partial layer progress is discarded, and caches are not strobed.
- Sample accepted at cycle T:
  - lsb_shift_en is high at T+1.
  - layer_start[0] is high at T+2.
  - Layer l done seen in its d_l-th WAIT cycle (d_l ≥ 1).
- out_valid rises at T + 3·NUM_LAYERS + 2 + Σ(d_l − 1), plus any CAPTURE stall cycles. With NUM_LAYERS=3 and all d_l=1, this is T+11.
- in_ready returns in the same cycle out_valid rises. The next sample computes while the previous result waits.
- Watchdog: err rises TIMEOUT cycles after the first WAIT cycle of the hung layer, and in_ready returns in the same cycle.

## Test plan

- Basic latency: NUM_LAYERS=3, done-latency 1 on each layer, in_valid pulse at T with inp=0x1234. Required: lsb_data=0x1234 and lsb_shift_en at T+1; layer_start pulses at T+2, T+5, T+8; cache_shift_en[0] at T+4 and cache_shift_en[1] at T+7; out=layer_out and out_valid at T+11; sample_cnt=1.
- Backpressure: out_ready=0, two samples back to back. Required: second run stalls in CAPTURE with busy=1 and in_ready=0. Raising out_ready loads the second result in that cycle with out_valid held high; sample_cnt=2.
- Variable layer latency: done delays 1/5/3 cycles. Required: out_valid at T+17; no strobe overlaps; stray layer_done pulses on other bits or in IDLE are ignored.
- Watchdog: TIMEOUT=8, layer 1 never asserts done. Required: err=1 eight cycles after its WAIT begins; return to IDLE; no cache_shift_en[1]; out_valid stays 0; sample_cnt unchanged; err persists across later good samples.
- Reset mid-run: assert rst=0 during WAIT of layer 1. Required: all outputs at reset values asynchronously. After release, a new sample completes normally with nominal latency.
- NUM_LAYERS=1: sample at T. Required: layer_start[0] at T+2, out_valid at T+5, cache_shift_en never asserted.
